// File: rtl/weight_port_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// weight_port_arbiter
//
// Shares the single weight-memory read port among NUM_REQ layer schedulers.
// Requesters are granted round-robin. The arbiter then launches one burst on
// the memory reader and steers the returning beats and the done pulse back to
// the owner with no added latency.
//
// Ports
//   CLK, RESET            clock (rising edge), asynchronous active-low reset
//   req_in    [N]         per-requester burst request, held until granted
//   base_in   [N*ADDR_W]  per-requester burst base address
//   count_in  [N*CNT_W]   per-requester burst length in beats
//   grant_out [N]         one-cycle one-hot grant pulse
//   valid_out [N]         beat valid steered to the owner (combinational)
//   data_out  [DATA_W]    beat data, broadcast from mem_data
//   done_out  [N]         burst-complete pulse to the owner
//   mem_ready             reader idle, may accept mem_start
//   mem_start             one-cycle burst launch to the reader
//   mem_base / mem_count  latched burst base and length
//   mem_valid/data/done   beat stream and completion from the reader
//   busy                  burst in progress
//   owner_id              index of the current or last owner
//   err                   sticky protocol error
// -----------------------------------------------------------------------------
module weight_port_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 19,
  parameter int CNT_W   = 11,
  parameter int DATA_W  = 128,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [NUM_REQ-1:0]        req_in,
  input  logic [NUM_REQ*ADDR_W-1:0] base_in,
  input  logic [NUM_REQ*CNT_W-1:0]  count_in,
  output logic [NUM_REQ-1:0]        grant_out,
  output logic [NUM_REQ-1:0]        valid_out,
  output logic [DATA_W-1:0]         data_out,
  output logic [NUM_REQ-1:0]        done_out,
  input  logic                      mem_ready,
  output logic                      mem_start,
  output logic [ADDR_W-1:0]         mem_base,
  output logic [CNT_W-1:0]          mem_count,
  input  logic                      mem_valid,
  input  logic [DATA_W-1:0]         mem_data,
  input  logic                      mem_done,
  output logic                      busy,
  output logic [ID_W-1:0]           owner_id,
  output logic                      err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_STREAM, S_ZERO} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   win_id;
  logic              win_found;
  logic [CNT_W-1:0]  win_count;
  logic [CNT_W-1:0]  beat_cnt;
  logic [ID_W-1:0]   next_rr;
  logic              zero_done;
  logic              launch;
  logic              in_stream;
  logic              err_event;

  // Round-robin search: first requester at or after rr_ptr, wrapping.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && req_in[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  assign win_count = count_in[win_id*CNT_W +: CNT_W];
  assign launch    = (state == S_IDLE) && mem_ready && win_found;
  assign in_stream = (state == S_STREAM);
  assign next_rr   = (owner_id == ID_W'(NUM_REQ - 1)) ? '0 : owner_id + 1'b1;
  assign busy      = (state != S_IDLE);
  assign data_out  = mem_data;

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (launch) state_nxt = (win_count == '0) ? S_ZERO : S_ISSUE;
      S_ISSUE:  state_nxt = S_STREAM;
      S_STREAM: if (mem_done) state_nxt = S_IDLE;
      S_ZERO:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Zero-latency steering. Stray beats/dones outside S_STREAM go nowhere.
  always_comb begin
    valid_out = '0;
    done_out  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (owner_id == ID_W'(k)) begin
        valid_out[k] = in_stream & mem_valid;
        done_out[k]  = (in_stream & mem_done) | zero_done;
      end
    end
  end

  // Protocol checks; a done must land exactly on the last beat count,
  // counting a beat that arrives in the same cycle.
  always_comb begin
    err_event = 1'b0;
    if (!in_stream && (mem_valid || mem_done)) err_event = 1'b1;
    if (in_stream && mem_valid && (beat_cnt >= mem_count)) err_event = 1'b1;
    if (in_stream && mem_done &&
        (({1'b0, beat_cnt} + (CNT_W+1)'(mem_valid)) != {1'b0, mem_count}))
      err_event = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      owner_id  <= '0;
      grant_out <= '0;
      mem_start <= 1'b0;
      mem_base  <= '0;
      mem_count <= '0;
      beat_cnt  <= '0;
      zero_done <= 1'b0;
      err       <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state     <= state_nxt;
      grant_out <= '0;
      mem_start <= (state == S_ISSUE);
      zero_done <= (state == S_ZERO);

      if (launch) begin
        grant_out <= NUM_REQ'(1) << win_id;
        mem_base  <= base_in[win_id*ADDR_W +: ADDR_W];
        mem_count <= win_count;
        owner_id  <= win_id;
        beat_cnt  <= '0;
      end

      // Saturating beat counter
      if (in_stream && mem_valid && (beat_cnt != '1))
        beat_cnt <= beat_cnt + 1'b1;

      if ((in_stream && mem_done) || (state == S_ZERO))
        rr_ptr <= next_rr;

      if (err_event)
        err <= 1'b1;
    end
  end

endmodule
